// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the hazard scoreboard.
// The decode stage is the master; the scoreboard is the slave.
interface hazard_scoreboard_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic                  dec_valid;
  logic                  dec_rs_vld;
  logic [REG_W-1:0]      dec_rs;
  logic                  dec_rt_vld;
  logic [REG_W-1:0]      dec_rt;
  logic                  dec_wr;
  logic [REG_W-1:0]      dec_rd;
  logic                  dec_load;
  logic                  flush;
  logic                  stall;
  logic                  issue;
  logic [2**REG_W-1:0]   pending;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output dec_valid, dec_rs_vld, dec_rs, dec_rt_vld, dec_rt,
           dec_wr, dec_rd, dec_load, flush,
    input  stall, issue, pending, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_rs_vld, dec_rs, dec_rt_vld, dec_rt,
           dec_wr, dec_rd, dec_load, flush,
    output stall, issue, pending, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: a shift-register scoreboard of in-flight register
// writes, compared against the decode sources to produce the fetch/decode stall.
module hazard_scoreboard #(
  parameter int REG_W     = 3,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 0,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             load;
  } slotT;

  slotT             slots [DEPTH];
  logic             hazard;
  logic             stallSig;
  logic             issueSig;
  logic [2**REG_W-1:0] pendingVec;
  logic [CNT_W-1:0] stallCnt;

  // A slot is visible to decode unless it is the WB slot and the register
  // file already bypasses the write into the same-cycle read.
  function automatic logic visible(input int s);
    return (s < DEPTH-1) || (WB_BYPASS == 0);
  endfunction

  function automatic logic hits(input slotT sl, input logic srcVld,
                                input logic [REG_W-1:0] src);
    return sl.vld & srcVld & (sl.rd == src);
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    hazard     = 1'b0;
    pendingVec = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (visible(s)) begin
        if (hits(slots[s], bus.dec_rs_vld, bus.dec_rs) ||
            hits(slots[s], bus.dec_rt_vld, bus.dec_rt)) begin
          if (FWD_EN == 0)
            hazard = 1'b1;
          else if (s == 0 && slots[0].load)
            hazard = 1'b1;
        end
        if (slots[s].vld)
          pendingVec[slots[s].rd] = 1'b1;
      end
    end
  end

  // Flush and reset dominate; a stall never coexists with an issue.
  assign stallSig = bus.dec_valid & ~bus.flush & ~rst & hazard;
  assign issueSig = bus.dec_valid & ~stallSig & ~bus.flush & ~rst;

  // NOTE: the slot array is a handful of flops, so every entry is reset; a
  // stale vld surviving reset would raise a phantom stall afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++)
        slots[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every slot read its neighbour's
      // pre-edge value, which is what makes this a shift register.
      slots[0] <= issueSig ? slotT'{bus.dec_wr, bus.dec_rd, bus.dec_load} : slotT'('0);
      for (int s = 1; s < DEPTH; s++)
        slots[s] <= slots[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stallCnt <= '0;
    else if (stallSig && (stallCnt != '1))
      stallCnt <= stallCnt + 1'b1;
  end

  assign bus.stall     = stallSig;
  assign bus.issue     = issueSig;
  assign bus.pending   = rst ? '0 : pendingVec;
  assign bus.stall_cnt = stallCnt;

endmodule
